// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the issue logic, muldiv_unit and the register file.
// Ports: start/op/operand_a/operand_b/dest_reg flow toward the unit (master drives);
//        busy/done/reg_write/write_register/write_data flow back (slave drives).
interface muldiv_unit_if #(
   parameter int size = 32
);
   logic            start;
   logic [1:0]      op;
   logic [size-1:0] operand_a;
   logic [size-1:0] operand_b;
   logic [4:0]      dest_reg;
   logic            busy;
   logic            done;
   logic            reg_write;
   logic [4:0]      write_register;
   logic [size-1:0] write_data;

   modport master (
      output start, op, operand_a, operand_b, dest_reg,
      input  busy, done, reg_write, write_register, write_data
   );

   modport slave (
      input  start, op, operand_a, operand_b, dest_reg,
      output busy, done, reg_write, write_register, write_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULH/DIV/REM unit feeding the register file write port.
// Latency: fixed size+1 cycles from acceptance; reg_write/done pulse for one cycle.
// Backpressure: none queued; start is sampled only in IDLE and ignored while busy.
// Ports: clk, rst (async, active-high), bus (muldiv_unit_if slave: request in, write-back out).
module muldiv_unit #(
   parameter int size  = 32,
   parameter int cnt_w = 6
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   state_t          state;
   logic [cnt_w-1:0] cnt;
   logic [1:0]      op_q;
   logic [4:0]      dest_q;
   // m_q is the multiplicand or divisor. hi_q/lo_q form the double-width
   // working register: {product upper, multiplier} or {remainder, dividend/quotient}.
   logic [size-1:0] m_q;
   logic [size-1:0] hi_q;
   logic [size-1:0] lo_q;

   logic            busy_q;
   logic            done_q;
   logic            reg_write_q;
   logic [4:0]      write_register_q;
   logic [size-1:0] write_data_q;

   logic [size-1:0] hi_n;
   logic [size-1:0] lo_n;
   logic [size:0]   mul_sum;
   logic [size:0]   div_trial;
   logic [size:0]   div_diff;

   // One iteration of either algorithm, selected by op_q[1].
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      div_trial = {hi_q, lo_q[size-1]};
      div_diff  = div_trial - {1'b0, m_q};
      hi_n      = hi_q;
      lo_n      = lo_q;
      if (!op_q[1]) begin
         // Shift-add: carry lands in the top bit, consumed multiplier bit falls out.
         hi_n = mul_sum[size:1];
         lo_n = {mul_sum[0], lo_q[size-1:1]};
      end else if (!div_diff[size]) begin
         hi_n = div_diff[size-1:0];
         lo_n = {lo_q[size-2:0], 1'b1};
      end else begin
         // Restore: keep the shifted remainder, quotient bit is 0.
         hi_n = div_trial[size-1:0];
         lo_n = {lo_q[size-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         op_q             <= '0;
         dest_q           <= '0;
         m_q              <= '0;
         hi_q             <= '0;
         lo_q             <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  dest_q <= bus.dest_reg;
                  m_q    <= bus.op[1] ? bus.operand_b : bus.operand_a;
                  lo_q   <= bus.op[1] ? bus.operand_a : bus.operand_b;
                  hi_q   <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               hi_q <= hi_n;
               lo_q <= lo_n;
               cnt  <= cnt + 1'b1;
               if (cnt == cnt_w'(size - 1)) begin
                  // Low half holds MUL/DIV results, high half MULH/REM.
                  state            <= WB;
                  reg_write_q      <= 1'b1;
                  done_q           <= 1'b1;
                  write_register_q <= dest_q;
                  write_data_q     <= op_q[0] ? hi_n : lo_n;
               end
            end
            WB: begin
               state       <= IDLE;
               busy_q      <= 1'b0;
               reg_write_q <= 1'b0;
               done_q      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.reg_write      = reg_write_q;
   assign bus.write_register = write_register_q;
   assign bus.write_data     = write_data_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed and random ops against an arithmetic reference model,
// with a behavioural register file capturing write-backs.
// Ports: none; drives the unit through a muldiv_unit_if instance.
module tb_muldiv_unit;
   localparam int SIZE = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_unit_if #(.size(SIZE)) bus ();
   muldiv_unit #(.size(SIZE), .cnt_w(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [SIZE-1:0] rf [32];
   int n_chk = 0;
   int n_err = 0;

   always @(posedge clk)
      if (bus.reg_write) rf[bus.write_register] <= bus.write_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] model(input logic [1:0] o, input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (o)
         2'd0:    return p[31:0];
         2'd1:    return p[63:32];
         2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Present a request and let it be accepted at the next edge, then scramble the inputs.
   task automatic start_op(input logic [1:0] o, input logic [SIZE-1:0] a,
                           input logic [SIZE-1:0] b, input logic [4:0] d);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
      bus.dest_reg = 5'($urandom);
      check("busy_on_accept", {63'd0, bus.busy}, 64'd1);
   endtask

   // Follow a run to completion; optionally pulse start with other operands at edge poke_at.
   task automatic finish_op(input logic [SIZE-1:0] exp, input logic [4:0] d, input int poke_at);
      int edges = 0;
      int writes = 0;
      int busy_cycles = 1;
      while (edges < SIZE + 4) begin
         @(posedge clk); #1;
         edges++;
         bus.start = 1'b0;
         if (bus.busy) busy_cycles++;
         if (bus.done !== bus.reg_write) check("done_eq_reg_write", {63'd0, bus.done}, {63'd0, bus.reg_write});
         if (bus.reg_write) begin
            writes++;
            check("latency_edges", 64'(edges), 64'(SIZE));
            check("write_register", {59'd0, bus.write_register}, {59'd0, d});
            check("write_data", {32'd0, bus.write_data}, {32'd0, exp});
         end
         if (edges == poke_at) begin
            bus.start = 1'b1; bus.op = 2'($urandom);
            bus.operand_a = $urandom; bus.operand_b = $urandom; bus.dest_reg = 5'($urandom);
         end
      end
      check("write_count", 64'(writes), 64'd1);
      check("busy_cycles", 64'(busy_cycles), 64'(SIZE + 1));
      check("rf_after_op", {32'd0, rf[d]}, {32'd0, exp});
   endtask

   task automatic run_op(input logic [1:0] o, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [4:0] d, input int poke_at);
      start_op(o, a, b, d);
      finish_op(model(o, a, b), d, poke_at);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_reg = '0;
      #2;
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
      check("rst_write_register", {59'd0, bus.write_register}, 64'd0);
      check("rst_write_data", {32'd0, bus.write_data}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_op(2'd0, 32'd7, 32'd6, 5'd5, 0);
      check("mul_7x6", {32'd0, rf[5]}, 64'd42);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0);
      check("mulh_max", {32'd0, rf[6]}, 64'hFFFF_FFFE);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
      check("mul_max", {32'd0, rf[7]}, 64'h1);
      run_op(2'd2, 32'd100, 32'd7, 5'd3, 0);
      run_op(2'd3, 32'd100, 32'd7, 5'd4, 0);
      check("rf3_div", {32'd0, rf[3]}, 64'd14);
      check("rf4_rem", {32'd0, rf[4]}, 64'd2);
      run_op(2'd2, 32'd5, 32'd0, 5'd8, 0);
      check("div_by_zero", {32'd0, rf[8]}, 64'hFFFF_FFFF);
      run_op(2'd3, 32'd5, 32'd0, 5'd9, 0);
      check("rem_by_zero", {32'd0, rf[9]}, 64'd5);
      run_op(2'd0, 32'd1234, 32'd5678, 5'd10, 10);
      check("poke_ignored", {32'd0, rf[10]}, 64'd7006652);
      run_op(2'd2, 32'd77, 32'd7, 5'd0, 0);
      check("dest_zero", {32'd0, rf[0]}, 64'd11);

      // Reset part-way through a divide: outputs drop without an edge, nothing is written.
      start_op(2'd2, 32'd1000, 32'd3, 5'd3);
      repeat (19) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrun_rst_busy", {63'd0, bus.busy}, 64'd0);
      check("midrun_rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
      check("midrun_rst_done", {63'd0, bus.done}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (SIZE + 4) @(posedge clk);
      check("rst_rf_unchanged", {32'd0, rf[3]}, 64'd14);
      run_op(2'd0, 32'd3, 32'd3, 5'd12, 0);
      check("mul_after_rst", {32'd0, rf[12]}, 64'd9);

      for (int i = 0; i < 12; i++) begin
         logic [1:0] o;
         logic [SIZE-1:0] a, b;
         o = 2'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 28);
         run_op(o, a, b, 5'($urandom), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide execution unit.
- Sits between the register file read ports and the register file write port.
- Takes two operands from read_data_1/read_data_2, computes over a fixed number of cycles, then issues a single-cycle register write.
- Handles MUL/MULH/DIV/REM, which the single-cycle ALU does not implement.

Parameters:
- size, 32, operand and result width in bits.
- cnt_w, 6, iteration counter width; must satisfy 2^cnt_w > size.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MUL low, 01 MUL high, 10 DIV quotient, 11 REM remainder.
- operand_a  input  size  multiplicand or dividend (from read_data_1).
- operand_b  input  size  multiplier or divisor (from read_data_2).
- dest_reg  input  5  destination register index.
- busy  output  1  high from acceptance until the write-back cycle ends.
- done  output  1  one-cycle pulse, coincident with reg_write.
- reg_write  output  1  register file write enable.
- write_register  output  5  register file write address.
- write_data  output  size  register file write data.

Behaviour:
- The clock is clk and the reset is rst. Reset is asynchronous and active-high.
- Reset values: busy=0, done=0, reg_write=0, write_register=0, write_data=0. State=IDLE, counter=0, all datapath registers 0.
- All outputs are registered.
- States:
  - IDLE: on posedge with start=1, latch op, operand_a, operand_b and dest_reg; clear the accumulator; counter=0; go to RUN; busy=1. start=0 stays in IDLE.
  - RUN: one bit processed per posedge; counter increments. After the size-th RUN edge (counter==size-1 at that edge), go to WB.
  - WB: reg_write=1, done=1, write_register=latched dest_reg, write_data=selected result, for exactly one cycle. The next posedge returns to IDLE with busy=0, reg_write=0, done=0.
- Latency:
  - Start accepted at edge E0.
  - reg_write is high during the cycle after edge E(size); the register file captures at edge E(size+1).
  - Latency is fixed at size+1 cycles for every op, including divide-by-zero.
- Next request: start may be raised again in the cycle after WB. It is accepted at the first IDLE edge; there are no back-to-back issues during WB.
- Multiply: shift-add on a 2*size-bit product register.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper half with a size+1-bit carry, then shift the product right by 1.
  - MUL returns product[size-1:0]; MULH returns product[2*size-1:size].
  - Unsigned only; wraps modulo 2^(2*size).
- Divide: restoring division, size iterations.
  - Each cycle: shift {rem,quot} left by 1, bringing in the dividend MSB.
  - Trial-subtract the divisor from rem (size+1 bits). If non-negative, keep the difference and set the quotient LSB; otherwise restore.
  - DIV returns the quotient; REM returns the remainder.
- Divide by zero: quotient = all ones (32'hFFFFFFFF); remainder = operand_a. This falls out naturally from restoring division; no special latency.
- Operands and op are captured at acceptance. Input changes during RUN/WB have no effect.
- start while busy is ignored (not queued), and no error is flagged.
- dest_reg=0 is written like any other index; the register file has no hardwired zero.
- Reset mid-RUN or mid-WB: return to IDLE immediately and asynchronously. reg_write drops at once and no partial result is ever written.

Test Plan:
- MUL 7*6, dest_reg=5 -> busy for 33 cycles; reg_write/done high exactly one cycle with write_register=5, write_data=42; done seen at cycle 33 after start.
- MULH and MUL of 32'hFFFFFFFF*32'hFFFFFFFF -> MULH writes 32'hFFFFFFFE; MUL writes 32'h00000001.
- DIV/REM 100 by 7, dest 3 then 4 -> reg 3 = 14, reg 4 = 2; check the register file contents through the read ports afterwards.
- DIV and REM 5 by 0 -> DIV writes 32'hFFFFFFFF, REM writes 5; same 33-cycle latency.
- Pulse start with different operands at cycle 10 of a run -> ignored; the original result is written once; no second reg_write follows.
- Assert rst at cycle 20 of a DIV -> busy, reg_write and done go to 0 without a clock edge; the destination register is unchanged; a new MUL 3*3 after reset writes 9.
